// File: rtl/blink_pkg.sv
// blink_pkg: shared state encoding, score limits and points helper for the Blink score path
package blink_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, PLAY, ADD, SETTLE, DONE} score_state_t;

    localparam int SCORE_W_DEF = 4;
    localparam int SCORE_MAX   = 2**SCORE_W_DEF - 1;

    function automatic logic [2:0] points(input logic [1:0] level);
        return {1'b0, level} + 3'd1;
    endfunction

endpackage

// File: rtl/score_controller_if.sv
// score_controller_if: game-FSM and accumulator signals seen by the score controller
interface score_controller_if #(parameter int SCORE_W = 4);

    logic               start;
    logic               hit;
    logic               miss;
    logic [1:0]         level;
    logic [SCORE_W-1:0] acc_Q;
    logic               acc_LD;
    logic               acc_CLR;
    logic [SCORE_W-1:0] acc_D;
    logic               busy;
    logic [2:0]         lives;
    logic               game_over;
    logic               max_reached;
    logic [SCORE_W-1:0] high_score;
    logic               new_record;

    modport master (
        output start, hit, miss, level, acc_Q,
        input  acc_LD, acc_CLR, acc_D, busy, lives, game_over, max_reached, high_score, new_record
    );

    modport slave (
        input  start, hit, miss, level, acc_Q,
        output acc_LD, acc_CLR, acc_D, busy, lives, game_over, max_reached, high_score, new_record
    );

endinterface

// File: rtl/score_controller.sv
// score_controller: sequences the Blink score accumulator, lives and end-of-game; HIGH_SCORE_EN adds a best-score register
module score_controller
    import blink_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int LIVES   = 3
) (
    input  logic               clk,
    input  logic               CLR_n,
    score_controller_if.slave  bus
);

    localparam logic [SCORE_W:0] MAX = {1'b0, {SCORE_W{1'b1}}};

    score_state_t       state;
    logic               pending;
    logic               acc_ld;
    logic               acc_clr;
    logic [SCORE_W-1:0] acc_d;
    logic               busy;
    logic [2:0]         lives;
    logic               game_over;
    logic               max_reached;
    logic [SCORE_W:0]   room;
    logic [SCORE_W:0]   pts;
    logic [SCORE_W:0]   add_d;

    // headroom below MAX limits the addend so the accumulator saturates instead of wrapping
    assign room  = MAX - {1'b0, bus.acc_Q};
    assign pts   = (SCORE_W+1)'(points(bus.level));
    assign add_d = (pts < room) ? pts : room;

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score;
    logic               new_record;
`endif

    // game sequencer with registered accumulator commands and status flags
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state       <= IDLE;
            lives       <= 3'(LIVES);
            pending     <= 1'b0;
            game_over   <= 1'b0;
            max_reached <= 1'b0;
            acc_ld      <= 1'b0;
            acc_d       <= '0;
            acc_clr     <= 1'b1;
            busy        <= 1'b0;
`ifdef HIGH_SCORE_EN
            high_score  <= '0;
            new_record  <= 1'b0;
`endif
        end else begin
            acc_ld  <= 1'b0;
            acc_d   <= '0;
            acc_clr <= 1'b0;
            busy    <= 1'b0;
`ifdef HIGH_SCORE_EN
            new_record <= 1'b0;
`endif
            if (bus.start && state != CLEAR) begin
                state       <= CLEAR;
                acc_clr     <= 1'b1;
                busy        <= 1'b1;
                lives       <= 3'(LIVES);
                pending     <= 1'b0;
                game_over   <= 1'b0;
                max_reached <= 1'b0;
            end else begin
                case (state)
                    IDLE:  acc_clr <= 1'b1;
                    CLEAR: state <= PLAY;
                    PLAY: begin
                        if (bus.miss) begin
                            lives <= lives - 3'd1;
                            if (lives == 3'd1) begin
                                state     <= DONE;
                                game_over <= 1'b1;
`ifdef HIGH_SCORE_EN
                                if (bus.acc_Q > high_score) begin
                                    high_score <= bus.acc_Q;
                                    new_record <= 1'b1;
                                end
`endif
                            end
                        end else if (bus.hit) begin
                            state  <= ADD;
                            acc_ld <= 1'b1;
                            acc_d  <= add_d[SCORE_W-1:0];
                            busy   <= 1'b1;
                        end
                    end
                    ADD: begin
                        state <= SETTLE;
                        busy  <= 1'b1;
                        if (bus.hit)
                            pending <= 1'b1;
                    end
                    SETTLE: begin
                        pending <= 1'b0;
                        if ({1'b0, bus.acc_Q} == MAX) begin
                            state       <= DONE;
                            max_reached <= 1'b1;
`ifdef HIGH_SCORE_EN
                            if (bus.acc_Q > high_score) begin
                                high_score <= bus.acc_Q;
                                new_record <= 1'b1;
                            end
`endif
                        end else if (pending || bus.hit) begin
                            state  <= ADD;
                            acc_ld <= 1'b1;
                            acc_d  <= add_d[SCORE_W-1:0];
                            busy   <= 1'b1;
                        end else begin
                            state <= PLAY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.acc_LD      = acc_ld;
    assign bus.acc_CLR     = acc_clr;
    assign bus.acc_D       = acc_d;
    assign bus.busy        = busy;
    assign bus.lives       = lives;
    assign bus.game_over   = game_over;
    assign bus.max_reached = max_reached;

`ifdef HIGH_SCORE_EN
    assign bus.high_score = high_score;
    assign bus.new_record = new_record;
`else
    assign bus.high_score = '0;
    assign bus.new_record = 1'b0;
`endif

endmodule

// File: tb/tb_score_controller.sv
// tb_score_controller: scoreboard bench for score_controller with a behavioural accumulator
module tb_score_controller;

    logic clk = 1'b0;
    logic CLR_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   e;

`ifdef HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    score_controller_if #(.SCORE_W(4)) bus();

    score_controller #(.SCORE_W(4), .LIVES(3)) dut (
        .clk   (clk),
        .CLR_n (CLR_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // external accumulator: synchronous clear, Q <= Q + D on load
    always_ff @(posedge clk)
        bus.acc_Q <= bus.acc_CLR ? 4'd0 : bus.acc_LD ? bus.acc_Q + bus.acc_D : bus.acc_Q;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor: every load pops one expected addend; no load means addend must be zero
    always @(negedge clk) begin
        checks++;
        if (bus.acc_LD) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: acc_D=%0d with no load expected", bus.acc_D);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus.acc_D) != e) begin
                    errors++;
                    $display("FAIL load_addend: got %0d expected %0d", bus.acc_D, e);
                end
            end
        end else if (bus.acc_D != 4'd0) begin
            errors++;
            $display("FAIL idle_addend: got %0d expected 0", bus.acc_D);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic h, input logic m);
        bus.hit  = h;
        bus.miss = m;
        @(negedge clk);
        bus.hit  = 1'b0;
        bus.miss = 1'b0;
    endtask

    task automatic do_hit(input int d);
        exp_q.push_back(d);
        pulse(1'b1, 1'b0);
        cyc(2);
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("clear_busy", bus.busy, 1);
        chk("clear_acc_clr", bus.acc_CLR, 1);
        @(negedge clk);
        chk("play_acc_clr", bus.acc_CLR, 0);
        chk("play_lives", bus.lives, 3);
        chk("play_acc_q", bus.acc_Q, 0);
    endtask

    initial begin
        CLR_n     = 1'b0;
        bus.start = 1'b0;
        bus.hit   = 1'b0;
        bus.miss  = 1'b0;
        bus.level = 2'd0;
        cyc(2);
        chk("rst_acc_clr", bus.acc_CLR, 1);
        chk("rst_acc_ld", bus.acc_LD, 0);
        chk("rst_lives", bus.lives, 3);
        chk("rst_busy", bus.busy, 0);
        chk("rst_game_over", bus.game_over, 0);
        chk("rst_max_reached", bus.max_reached, 0);
        chk("rst_high_score", bus.high_score, 0);
        chk("rst_new_record", bus.new_record, 0);
        CLR_n = 1'b1;
        cyc(1);
        chk("idle_acc_clr", bus.acc_CLR, 1);
        // reset asserted while the controller is in ADD
        start_game();
        bus.level = 2'd2;
        exp_q.push_back(3);
        pulse(1'b1, 1'b0);
        #2 CLR_n = 1'b0;
        #1;
        chk("midadd_acc_clr", bus.acc_CLR, 1);
        chk("midadd_acc_ld", bus.acc_LD, 0);
        chk("midadd_lives", bus.lives, 3);
        chk("midadd_busy", bus.busy, 0);
        @(negedge clk);
        CLR_n = 1'b1;
        cyc(1);
        // level 2 game to 9, then lose all lives
        start_game();
        bus.level = 2'd2;
        repeat (3) do_hit(3);
        chk("g1_score", bus.acc_Q, 9);
        chk("g1_play_busy", bus.busy, 0);
        chk("g1_lives", bus.lives, 3);
        pulse(1'b1, 1'b1);
        chk("hitmiss_lives", bus.lives, 2);
        pulse(1'b0, 1'b1);
        chk("miss2_lives", bus.lives, 1);
        chk("miss2_game_over", bus.game_over, 0);
        pulse(1'b0, 1'b1);
        chk("miss3_lives", bus.lives, 0);
        chk("miss3_game_over", bus.game_over, 1);
        chk("miss3_max_reached", bus.max_reached, 0);
        chk("g1_high_score", bus.high_score, HS ? 9 : 0);
        chk("g1_new_record", bus.new_record, HS ? 1 : 0);
        cyc(1);
        chk("g1_record_pulse_end", bus.new_record, 0);
        pulse(1'b0, 1'b1);
        chk("done_miss_lives", bus.lives, 0);
        pulse(1'b1, 1'b0);
        cyc(2);
        chk("done_hit_score", bus.acc_Q, 9);
        // hits held through ADD and SETTLE: one pending, third lost
        start_game();
        chk("restart_game_over", bus.game_over, 0);
        bus.level = 2'd0;
        exp_q.push_back(1);
        exp_q.push_back(1);
        bus.hit = 1'b1;
        cyc(3);
        bus.hit = 1'b0;
        cyc(3);
        chk("pending_score", bus.acc_Q, 2);
        chk("pending_busy", bus.busy, 0);
        repeat (3) do_hit(1);
        chk("g2_score", bus.acc_Q, 5);
        repeat (3) pulse(1'b0, 1'b1);
        chk("g2_game_over", bus.game_over, 1);
        chk("g2_high_score", bus.high_score, HS ? 9 : 0);
        chk("g2_new_record", bus.new_record, 0);
        // saturate at max: 4+4+4+1 then level 3 gives only 2
        start_game();
        bus.level = 2'd3;
        repeat (3) do_hit(4);
        bus.level = 2'd0;
        do_hit(1);
        chk("g3_score13", bus.acc_Q, 13);
        bus.level = 2'd3;
        do_hit(2);
        chk("g3_score15", bus.acc_Q, 15);
        chk("g3_max_reached", bus.max_reached, 1);
        chk("g3_game_over", bus.game_over, 0);
        chk("g3_busy", bus.busy, 0);
        chk("g3_lives", bus.lives, 3);
        chk("g3_high_score", bus.high_score, HS ? 15 : 0);
        chk("g3_new_record", bus.new_record, HS ? 1 : 0);
        cyc(1);
        chk("g3_record_pulse_end", bus.new_record, 0);
        pulse(1'b1, 1'b0);
        cyc(2);
        chk("g3_done_score", bus.acc_Q, 15);
        chk("g3_done_max", bus.max_reached, 1);
        cyc(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
